// File: rtl/pipeline_types.sv
// Shared pipeline types for the out-of-order core: ROB sizing constants and the entry record.
package pipeline_types;

   localparam int ROB_DEPTH = 16;
   localparam int ROB_TAG_W = 4;
   localparam int PREG_W    = 6;
   localparam int LREG_W    = 5;

   typedef struct packed {
      logic              valid;
      logic              done;
      logic [LREG_W-1:0] rd_log;
      logic [PREG_W-1:0] rd_phys;
      logic [PREG_W-1:0] rd_old_phys;
      logic              is_branch;
      logic              mispredicted;
      logic [31:0]       pc;
   } rob_entry_t;

endpackage

// File: rtl/rob_if.sv
// Dispatch allocation, execution writeback and commit bundle around the reorder buffer.
interface rob_if;
   import pipeline_types::*;

   logic                 push;
   rob_entry_t           entry;
   logic                 full;
   logic                 empty;
   logic [ROB_TAG_W-1:0] alloc_tag;
   logic                 wb_valid;
   logic [ROB_TAG_W-1:0] wb_tag;
   logic                 wb_mispredict;
   logic                 commit_valid;
   logic                 commit_rd_valid;
   logic [PREG_W-1:0]    commit_rd_phys;
   logic [PREG_W-1:0]    commit_rd_old_phys;
   logic [31:0]          commit_pc;
   logic                 flush;

   modport master (
      output push, entry, wb_valid, wb_tag, wb_mispredict,
      input  full, empty, alloc_tag, commit_valid, commit_rd_valid,
             commit_rd_phys, commit_rd_old_phys, commit_pc, flush
   );

   modport slave (
      input  push, entry, wb_valid, wb_tag, wb_mispredict,
      output full, empty, alloc_tag, commit_valid, commit_rd_valid,
             commit_rd_phys, commit_rd_old_phys, commit_pc, flush
   );

endinterface

// File: rtl/rob.sv
// 16-entry circular reorder buffer: in-order allocate, out-of-order completion,
// in-order single-entry commit, whole-buffer flush when a mispredicted branch retires.
module rob
   import pipeline_types::*;
(
   input  logic clk,
   input  logic rst,
   rob_if.slave bus
);

   localparam int DEPTH = ROB_DEPTH;
   localparam int TAG_W = ROB_TAG_W;
   localparam logic [TAG_W:0] FULL_COUNT = (TAG_W+1)'(DEPTH);

   logic [TAG_W-1:0] head_reg, head_next;
   logic [TAG_W-1:0] tail_reg, tail_next;
   logic [TAG_W:0]   count_reg, count_next;

   logic [DEPTH-1:0] valid_vec;
   logic [DEPTH-1:0] done_vec;
   logic [DEPTH-1:0] mispred_vec;

   rob_entry_t payload_reg [DEPTH];
   rob_entry_t head_entry;
   rob_entry_t entry_w;

   logic push_ok;
   logic wb_ok;
   logic commit;
   logic flush;
   logic unused_debug;

   assign bus.full      = (count_reg == FULL_COUNT);
   assign bus.empty     = (count_reg == '0);
   assign bus.alloc_tag = tail_reg;

   assign head_entry = payload_reg[head_reg];
   assign commit     = !bus.empty && done_vec[head_reg];
   assign flush      = commit && mispred_vec[head_reg];

   // Flush wins over everything else arriving in the same cycle.
   assign push_ok = bus.push && !bus.full && !flush;
   assign wb_ok   = bus.wb_valid && valid_vec[bus.wb_tag] && !flush;

   assign bus.commit_valid       = commit;
   assign bus.commit_rd_valid    = commit && (head_entry.rd_phys != '0);
   assign bus.commit_rd_phys     = commit ? head_entry.rd_phys : '0;
   assign bus.commit_rd_old_phys = commit ? head_entry.rd_old_phys : '0;
   assign bus.commit_pc          = commit ? head_entry.pc : '0;
   assign bus.flush              = flush;

   // Debug-only fields travel with the payload but steer nothing.
   assign unused_debug = ^{head_entry.valid, head_entry.done, head_entry.rd_log,
                           head_entry.is_branch, head_entry.mispredicted};

   always_comb begin
      entry_w              = bus.entry;
      entry_w.valid        = 1'b1;
      entry_w.done         = 1'b0;
      entry_w.mispredicted = 1'b0;
   end

   always_comb begin
      head_next  = head_reg + TAG_W'(commit);
      tail_next  = tail_reg + TAG_W'(push_ok);
      count_next = count_reg + (TAG_W+1)'(push_ok) - (TAG_W+1)'(commit);
      if (flush) begin
         head_next  = '0;
         tail_next  = '0;
         count_next = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head_reg  <= '0;
         tail_reg  <= '0;
         count_reg <= '0;
      end else begin
         head_reg  <= head_next;
         tail_reg  <= tail_next;
         count_reg <= count_next;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) begin
         payload_reg[tail_reg] <= entry_w;
      end
   end

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
         logic entry_valid_reg;
         logic entry_done_reg;
         logic entry_mispred_reg;
         logic alloc_hit;
         logic wb_hit;
         logic commit_hit;

         assign alloc_hit  = push_ok && (tail_reg == TAG_W'(gi));
         assign wb_hit     = wb_ok && (bus.wb_tag == TAG_W'(gi));
         assign commit_hit = commit && (head_reg == TAG_W'(gi));

         always_ff @(posedge clk) begin
            if (rst || flush) begin
               entry_valid_reg   <= 1'b0;
               entry_done_reg    <= 1'b0;
               entry_mispred_reg <= 1'b0;
            end else if (alloc_hit) begin
               entry_valid_reg   <= 1'b1;
               entry_done_reg    <= 1'b0;
               entry_mispred_reg <= 1'b0;
            end else begin
               if (wb_hit) begin
                  entry_done_reg    <= 1'b1;
                  entry_mispred_reg <= entry_mispred_reg | bus.wb_mispredict;
               end
               if (commit_hit) begin
                  entry_valid_reg <= 1'b0;
                  entry_done_reg  <= 1'b0;
               end
            end
         end

         assign valid_vec[gi]   = entry_valid_reg;
         assign done_vec[gi]    = entry_done_reg;
         assign mispred_vec[gi] = entry_mispred_reg;
      end
   endgenerate

endmodule

// File: tb/tb_rob.sv
// Directed-vector bench for the reorder buffer: allocation, ordering, wrap, flush and stray writebacks.
module tb_rob;
   import pipeline_types::*;

   logic clk;
   logic rst;
   int   vectors;
   int   miscompares;

   rob_if bus();

   rob dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
      $display("[vec %0d] %s observed=%0h expected=%0h", vectors, tag, obs, exp);
   endtask

   // Control bits are deliberately set in the payload: the ROB must override them.
   function automatic rob_entry_t mk(input logic [31:0] pc, input logic [5:0] rp,
                                     input logic [5:0] op);
      rob_entry_t e;
      e.valid        = 1'b1;
      e.done         = 1'b1;
      e.rd_log       = 5'd3;
      e.rd_phys      = rp;
      e.rd_old_phys  = op;
      e.is_branch    = 1'b0;
      e.mispredicted = 1'b1;
      e.pc           = pc;
      return e;
   endfunction

   task automatic wb(input int tag, input logic mis);
      bus.wb_valid      = 1'b1;
      bus.wb_tag        = 4'(tag);
      bus.wb_mispredict = mis;
      tick();
      bus.wb_valid      = 1'b0;
      bus.wb_mispredict = 1'b0;
   endtask

   task automatic push_one(input logic [31:0] pc, input logic [5:0] rp, input logic [5:0] op);
      bus.push  = 1'b1;
      bus.entry = mk(pc, rp, op);
      tick();
      bus.push  = 1'b0;
   endtask

   initial begin
      vectors           = 0;
      miscompares       = 0;
      bus.push          = 1'b0;
      bus.entry         = '0;
      bus.wb_valid      = 1'b0;
      bus.wb_tag        = '0;
      bus.wb_mispredict = 1'b0;
      rst               = 1'b1;
      tick();
      tick();
      rst = 1'b0;

      check("reset_full", 32'(bus.full), 0);
      check("reset_empty", 32'(bus.empty), 1);
      check("reset_alloc_tag", 32'(bus.alloc_tag), 0);
      check("reset_commit_valid", 32'(bus.commit_valid), 0);
      check("reset_flush", 32'(bus.flush), 0);

      // Fill all 16 entries without completion.
      for (int i = 0; i < 16; i++) begin
         check("fill_alloc_tag", 32'(bus.alloc_tag), i);
         push_one(32'h1000 + 32'(4 * i), 6'(i + 1), 6'd0);
      end
      check("fill_full", 32'(bus.full), 1);
      check("fill_tail_wrapped", 32'(bus.alloc_tag), 0);
      push_one(32'hDEAD, 6'd9, 6'd9);
      check("overpush_full", 32'(bus.full), 1);
      check("overpush_tail", 32'(bus.alloc_tag), 0);
      check("overpush_no_commit", 32'(bus.commit_valid), 0);

      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midreset_empty", 32'(bus.empty), 1);
      check("midreset_full", 32'(bus.full), 0);
      check("midreset_commit_valid", 32'(bus.commit_valid), 0);

      // In-order commit despite out-of-order completion.
      push_one(32'd100, 6'd10, 6'd1);
      push_one(32'd104, 6'd11, 6'd2);
      push_one(32'd108, 6'd12, 6'd3);
      wb(2, 1'b0);
      check("ooo_wb2_no_commit", 32'(bus.commit_valid), 0);
      wb(0, 1'b0);
      check("ooo_tag0_commit", 32'(bus.commit_valid), 1);
      check("ooo_tag0_pc", bus.commit_pc, 100);
      tick();
      check("ooo_tag1_blocks", 32'(bus.commit_valid), 0);
      check("ooo_not_empty", 32'(bus.empty), 0);
      wb(1, 1'b0);
      check("ooo_tag1_commit", 32'(bus.commit_valid), 1);
      check("ooo_tag1_pc", bus.commit_pc, 104);
      tick();
      check("ooo_tag2_commit", 32'(bus.commit_valid), 1);
      check("ooo_tag2_pc", bus.commit_pc, 108);
      tick();
      check("ooo_drained", 32'(bus.empty), 1);

      // Destination vs no-destination commits (tags 3 and 4).
      push_one(32'd200, 6'd37, 6'd12);
      push_one(32'd204, 6'd0, 6'd5);
      bus.wb_valid = 1'b1;
      bus.wb_tag   = 4'd3;
      tick();
      bus.wb_tag = 4'd4;
      check("rd_commit_valid", 32'(bus.commit_valid), 1);
      check("rd_valid", 32'(bus.commit_rd_valid), 1);
      check("rd_phys", 32'(bus.commit_rd_phys), 37);
      check("rd_old_phys", 32'(bus.commit_rd_old_phys), 12);
      check("rd_pc", bus.commit_pc, 200);
      tick();
      bus.wb_valid = 1'b0;
      check("x0_commit_valid", 32'(bus.commit_valid), 1);
      check("x0_rd_valid", 32'(bus.commit_rd_valid), 0);
      check("x0_old_phys", 32'(bus.commit_rd_old_phys), 5);
      check("x0_pc", bus.commit_pc, 204);
      tick();
      check("x0_drained", 32'(bus.empty), 1);
      check("idle_old_phys_zero", 32'(bus.commit_rd_old_phys), 0);
      check("idle_pc_zero", bus.commit_pc, 0);

      // Full buffer: a same-cycle commit does not unblock a push.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 16; i++) push_one(32'h400 + 32'(4 * i), 6'(i + 1), 6'd0);
      for (int i = 1; i < 16; i++) wb(i, 1'b0);
      check("wrap_head_blocks", 32'(bus.commit_valid), 0);
      wb(0, 1'b0);
      check("wrap_full", 32'(bus.full), 1);
      check("wrap_commit_valid", 32'(bus.commit_valid), 1);
      check("wrap_commit_pc", bus.commit_pc, 32'h400);
      bus.push  = 1'b1;
      bus.entry = mk(32'hABC, 6'd20, 6'd21);
      tick();
      check("wrap_push_rejected_full", 32'(bus.full), 0);
      check("wrap_push_rejected_tail", 32'(bus.alloc_tag), 0);
      check("wrap_next_pc", bus.commit_pc, 32'h404);
      tick();
      bus.push = 1'b0;
      check("wrap_push_accepted_tail", 32'(bus.alloc_tag), 1);
      check("wrap_full_after", 32'(bus.full), 0);
      for (int k = 2; k < 16; k++) begin
         check("wrap_drain_pc", bus.commit_pc, 32'h400 + 32'(4 * k));
         tick();
      end
      check("wrap_new_not_done", 32'(bus.commit_valid), 0);
      check("wrap_new_not_empty", 32'(bus.empty), 0);
      wb(0, 1'b0);
      check("wrap_new_commit_pc", bus.commit_pc, 32'hABC);
      tick();
      check("wrap_drained", 32'(bus.empty), 1);

      // Mispredict flush with a push and a writeback in the flush cycle.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 8; i++) push_one(32'h300 + 32'(4 * i), 6'(i + 1), 6'd0);
      wb(0, 1'b0);
      wb(1, 1'b0);
      wb(2, 1'b0);
      tick();
      check("flush_pre_tail", 32'(bus.alloc_tag), 8);
      check("flush_pre_commit", 32'(bus.commit_valid), 0);
      wb(3, 1'b1);
      check("flush_asserted", 32'(bus.flush), 1);
      check("flush_commit_valid", 32'(bus.commit_valid), 1);
      check("flush_commit_pc", bus.commit_pc, 32'h30C);
      bus.push     = 1'b1;
      bus.entry    = mk(32'h777, 6'd7, 6'd7);
      bus.wb_valid = 1'b1;
      bus.wb_tag   = 4'd5;
      tick();
      bus.push     = 1'b0;
      bus.wb_valid = 1'b0;
      check("post_flush_empty", 32'(bus.empty), 1);
      check("post_flush_alloc_tag", 32'(bus.alloc_tag), 0);
      check("post_flush_full", 32'(bus.full), 0);
      check("post_flush_flush", 32'(bus.flush), 0);
      check("post_flush_commit", 32'(bus.commit_valid), 0);

      // Stray writeback to an unallocated tag must not mark it done.
      for (int i = 0; i < 9; i++) push_one(32'h500 + 32'(4 * i), 6'(i + 1), 6'd0);
      for (int i = 0; i < 9; i++) wb(i, 1'b0);
      tick();
      check("stray_pre_empty", 32'(bus.empty), 1);
      check("stray_pre_tail", 32'(bus.alloc_tag), 9);
      wb(9, 1'b0);
      check("stray_empty", 32'(bus.empty), 1);
      check("stray_commit", 32'(bus.commit_valid), 0);
      push_one(32'h900, 6'd33, 6'd4);
      check("stray_push_not_empty", 32'(bus.empty), 0);
      check("stray_push_tail", 32'(bus.alloc_tag), 10);
      check("stray_push_not_done", 32'(bus.commit_valid), 0);
      tick();
      check("stray_still_not_done", 32'(bus.commit_valid), 0);
      wb(9, 1'b0);
      check("stray_real_wb_commit", 32'(bus.commit_valid), 1);
      check("stray_real_wb_pc", bus.commit_pc, 32'h900);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
